// File: rtl/intersection_phase_scheduler_if.sv
// Sensor/button inputs and light/phase outputs of the intersection phase scheduler.
// master drives the sensors and buttons, slave is the scheduler itself.
interface intersection_phase_scheduler_if;
    logic       sa;
    logic       sb;
    logic       ba;
    logic       bb;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] pa;
    logic [1:0] pb;
    logic [2:0] phase;

    modport master (output sa, sb, ba, bb, input a, b, pa, pb, phase);
    modport slave  (input sa, sb, ba, bb, output a, b, pa, pb, phase);
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Demand-driven two-road phase sequencer with min/max green, yellow, all-red and ped walk timing.
// Latency: lights and phase are registered and change on the same edge as the state.
// Backpressure: none; sensors are sampled every cycle and button presses are latched until served.
module intersection_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3,
    parameter int FLASH_T   = 2,
    parameter int TW        = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    intersection_phase_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        RST_RED = 3'd0,
        A_GRN   = 3'd1,
        A_YEL   = 3'd2,
        RED_AB  = 3'd3,
        B_GRN   = 3'd4,
        B_YEL   = 3'd5,
        RED_BA  = 3'd6
    } state_t;

    localparam logic [1:0] CAR_RED = 2'b00;
    localparam logic [1:0] CAR_YEL = 2'b01;
    localparam logic [1:0] CAR_GRN = 2'b10;
    localparam logic [1:0] PED_DW  = 2'b00;
    localparam logic [1:0] PED_FL  = 2'b01;
    localparam logic [1:0] PED_WK  = 2'b10;

    localparam int WALK_MIN = (WALK_T + FLASH_T > GREEN_MIN) ? (WALK_T + FLASH_T) : GREEN_MIN;

    // Timer values at which a state of the given duration is on its last cycle.
    localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] T_YEL    = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] T_MIN    = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_MINW   = TW'(WALK_MIN - 1);
    localparam logic [TW-1:0] T_MAX    = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] T_WALK   = TW'(WALK_T);
    localparam logic [TW-1:0] T_FLASH  = TW'(WALK_T + FLASH_T);
    localparam logic [TW-1:0] T_SAT    = '1;

    state_t        state, nxt_state;
    logic [TW-1:0] timer, nxt_timer;
    logic          req_a, req_b, walk_a, walk_b;
    logic          nxt_req_a, nxt_req_b, nxt_walk_a, nxt_walk_b;
    logic          dem_a, dem_b, moved;
    logic [1:0]    car_a, car_b, ped_a, ped_b;
    logic [1:0]    nxt_car_a, nxt_car_b, nxt_ped_a, nxt_ped_b;

    function automatic logic [1:0] ped_code(input logic walk, input logic [TW-1:0] t);
        if (!walk)          return PED_DW;
        else if (t < T_WALK)  return PED_WK;
        else if (t < T_FLASH) return PED_FL;
        else                  return PED_DW;
    endfunction

    always_comb begin
        dem_a     = bus.sa | req_a;
        dem_b     = bus.sb | req_b;
        nxt_state = state;
        case (state)
            RST_RED: if (timer >= T_ALLRED) nxt_state = A_GRN;
            A_GRN:   if (timer >= (walk_a ? T_MINW : T_MIN) && dem_b && (!bus.sa || timer >= T_MAX))
                         nxt_state = A_YEL;
            A_YEL:   if (timer >= T_YEL)    nxt_state = RED_AB;
            RED_AB:  if (timer >= T_ALLRED) nxt_state = B_GRN;
            B_GRN:   if (timer >= (walk_b ? T_MINW : T_MIN) && dem_a && (!bus.sb || timer >= T_MAX))
                         nxt_state = B_YEL;
            B_YEL:   if (timer >= T_YEL)    nxt_state = RED_BA;
            RED_BA:  if (timer >= T_ALLRED) nxt_state = A_GRN;
            default: nxt_state = RST_RED;
        endcase

        moved     = (nxt_state != state);
        nxt_timer = moved ? '0 : ((timer == T_SAT) ? timer : timer + TW'(1));

        // A walk is granted on the entry edge; a press on that same edge re-latches for next time.
        nxt_walk_a = (moved && nxt_state == A_GRN) ? req_a : (walk_a && nxt_state == A_GRN);
        nxt_walk_b = (moved && nxt_state == B_GRN) ? req_b : (walk_b && nxt_state == B_GRN);
        nxt_req_a  = bus.ba | (req_a & ~(moved && nxt_state == A_GRN));
        nxt_req_b  = bus.bb | (req_b & ~(moved && nxt_state == B_GRN));

        nxt_car_a = (nxt_state == A_GRN) ? CAR_GRN : (nxt_state == A_YEL) ? CAR_YEL : CAR_RED;
        nxt_car_b = (nxt_state == B_GRN) ? CAR_GRN : (nxt_state == B_YEL) ? CAR_YEL : CAR_RED;
        nxt_ped_a = ped_code(nxt_walk_a, nxt_timer);
        nxt_ped_b = ped_code(nxt_walk_b, nxt_timer);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RST_RED;
            timer  <= '0;
            req_a  <= 1'b0;
            req_b  <= 1'b0;
            walk_a <= 1'b0;
            walk_b <= 1'b0;
            car_a  <= CAR_RED;
            car_b  <= CAR_RED;
            ped_a  <= PED_DW;
            ped_b  <= PED_DW;
        end else begin
            state  <= nxt_state;
            timer  <= nxt_timer;
            req_a  <= nxt_req_a;
            req_b  <= nxt_req_b;
            walk_a <= nxt_walk_a;
            walk_b <= nxt_walk_b;
            car_a  <= nxt_car_a;
            car_b  <= nxt_car_b;
            ped_a  <= nxt_ped_a;
            ped_b  <= nxt_ped_b;
        end
    end

    assign bus.a     = car_a;
    assign bus.b     = car_b;
    assign bus.pa    = ped_a;
    assign bus.pb    = ped_b;
    assign bus.phase = state;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler: phase timing, walks, reset and light invariants.
module tb_intersection_phase_scheduler;
    localparam logic [2:0] P_RST = 3'd0, P_AG = 3'd1, P_AY = 3'd2, P_RAB = 3'd3;
    localparam logic [2:0] P_BG  = 3'd4, P_BY = 3'd5, P_RBA = 3'd6;
    localparam logic [1:0] RED = 2'b00, YEL = 2'b01, GRN = 2'b10;
    localparam logic [1:0] DW  = 2'b00, FL  = 2'b01, WK  = 2'b10;

    logic clk = 1'b0;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;

    intersection_phase_scheduler_if bus ();

    intersection_phase_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check all outputs against the expected tuple for n consecutive cycles, advancing one clock each.
    task automatic run(input string tag, input logic [2:0] ph, input logic [1:0] ea, input logic [1:0] eb,
                       input logic [1:0] epa, input logic [1:0] epb, input int n);
        logic [10:0] got, want;
        for (int i = 0; i < n; i++) begin
            got  = {bus.phase, bus.a, bus.b, bus.pa, bus.pb};
            want = {ph, ea, eb, epa, epb};
            compared++;
            assert (got === want) else begin
                mismatched++;
                $error("FAIL %s cycle %0d: observed phase=%0d a=%0d b=%0d pa=%0d pb=%0d, expected phase=%0d a=%0d b=%0d pa=%0d pb=%0d",
                       tag, i, got[10:8], got[7:6], got[5:4], got[3:2], got[1:0],
                       ph, ea, eb, epa, epb);
            end
            step();
        end
    endtask

    initial begin
        logic [2:0] inv_got;
        bus.sa = 1'b0;
        bus.sb = 1'b0;
        bus.ba = 1'b0;
        bus.bb = 1'b0;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;
        step();
        step();
        run("reset_state", P_RST, RED, RED, DW, DW, 1);

        // Road B demand only from release: A gets the first green for its minimum.
        bus.sb = 1'b1;
        rst_n  = 1'b1;
        run("t1_rst_red", P_RST, RED, RED, DW, DW, 1);
        run("t1_a_grn",   P_AG,  GRN, RED, DW, DW, 4);
        run("t1_a_yel",   P_AY,  YEL, RED, DW, DW, 2);
        run("t1_red_ab",  P_RAB, RED, RED, DW, DW, 1);

        // Both roads loaded: strict alternation at GREEN_MAX.
        bus.sa = 1'b1;
        run("t2_b_grn",   P_BG,  RED, GRN, DW, DW, 12);
        run("t2_b_yel",   P_BY,  RED, YEL, DW, DW, 2);
        run("t2_red_ba",  P_RBA, RED, RED, DW, DW, 1);
        run("t2_a_grn",   P_AG,  GRN, RED, DW, DW, 12);
        run("t2_a_yel",   P_AY,  YEL, RED, DW, DW, 2);
        run("t2_red_ab",  P_RAB, RED, RED, DW, DW, 1);
        run("t2_b_grn2",  P_BG,  RED, GRN, DW, DW, 12);

        // Only road A loaded: A rests on green.
        bus.sb = 1'b0;
        run("t3_b_yel",   P_BY,  RED, YEL, DW, DW, 2);
        run("t3_red_ba",  P_RBA, RED, RED, DW, DW, 1);
        run("t3_a_rest",  P_AG,  GRN, RED, DW, DW, 50);

        // One-cycle B button: B green with walk, walk stretches B's minimum to 5.
        bus.sa = 1'b0;
        bus.bb = 1'b1;
        run("t4_press",   P_AG,  GRN, RED, DW, DW, 1);
        bus.bb = 1'b0;
        run("t4_a_last",  P_AG,  GRN, RED, DW, DW, 1);
        run("t4_a_yel",   P_AY,  YEL, RED, DW, DW, 2);
        run("t4_red_ab",  P_RAB, RED, RED, DW, DW, 1);
        bus.sa = 1'b1;
        run("t4_b_walk",  P_BG,  RED, GRN, DW, WK, 3);
        run("t4_b_flash", P_BG,  RED, GRN, DW, FL, 2);
        run("t4_b_yel",   P_BY,  RED, YEL, DW, DW, 2);
        run("t4_red_ba",  P_RBA, RED, RED, DW, DW, 1);

        // Latch reqA during B green, then reset mid B yellow: request must be dropped.
        bus.sa = 1'b0;
        bus.sb = 1'b1;
        run("t5_a_grn",   P_AG,  GRN, RED, DW, DW, 4);
        run("t5_a_yel",   P_AY,  YEL, RED, DW, DW, 2);
        run("t5_red_ab",  P_RAB, RED, RED, DW, DW, 1);
        bus.ba = 1'b1;
        run("t5_b_press", P_BG,  RED, GRN, DW, DW, 1);
        bus.ba = 1'b0;
        bus.sb = 1'b0;
        run("t5_b_grn",   P_BG,  RED, GRN, DW, DW, 3);
        run("t5_b_yel",   P_BY,  RED, YEL, DW, DW, 1);
        rst_n = 1'b0;
        #1;
        run("t5_async",   P_RST, RED, RED, DW, DW, 1);
        step();
        rst_n = 1'b1;
        run("t5_rst_red", P_RST, RED, RED, DW, DW, 1);
        run("t5_no_walk", P_AG,  GRN, RED, DW, DW, 3);

        // Button held across the A-green entry edge: walk runs and the latch stays set.
        bus.ba = 1'b1;
        bus.sb = 1'b1;
        run("t6_a_grn",   P_AG,  GRN, RED, DW, DW, 1);
        run("t6_a_yel",   P_AY,  YEL, RED, DW, DW, 2);
        run("t6_red_ab",  P_RAB, RED, RED, DW, DW, 1);
        bus.sb = 1'b0;
        run("t6_b_grn",   P_BG,  RED, GRN, DW, DW, 4);
        run("t6_b_yel",   P_BY,  RED, YEL, DW, DW, 2);
        run("t6_red_ba",  P_RBA, RED, RED, DW, DW, 1);
        bus.ba = 1'b0;
        run("t6_a_walk",  P_AG,  GRN, RED, WK, DW, 3);
        run("t6_a_flash", P_AG,  GRN, RED, FL, DW, 2);
        bus.sb = 1'b1;
        run("t6_a_end",   P_AG,  GRN, RED, DW, DW, 1);
        run("t6_a_yel2",  P_AY,  YEL, RED, DW, DW, 2);
        run("t6_red_ab2", P_RAB, RED, RED, DW, DW, 1);
        bus.sb = 1'b0;
        run("t6_b_grn2",  P_BG,  RED, GRN, DW, DW, 4);
        run("t6_b_yel2",  P_BY,  RED, YEL, DW, DW, 2);
        run("t6_red_ba2", P_RBA, RED, RED, DW, DW, 1);
        run("t6_rewalk",  P_AG,  GRN, RED, WK, DW, 1);

        // Random inputs: never two non-red roads, ped lights lit only during their own green.
        for (int i = 0; i < 400; i++) begin
            bus.sa = 1'($urandom_range(0, 1));
            bus.sb = 1'($urandom_range(0, 1));
            bus.ba = ($urandom_range(0, 7) == 0);
            bus.bb = ($urandom_range(0, 7) == 0);
            step();
            inv_got[2] = (bus.a != RED) && (bus.b != RED);
            inv_got[1] = (bus.pa != DW) && (bus.phase != P_AG);
            inv_got[0] = (bus.pb != DW) && (bus.phase != P_BG);
            compared++;
            assert (inv_got === 3'b000) else begin
                mismatched++;
                $error("FAIL invariant cycle %0d: observed violations (both_lit,pa,pb)=%b expected 000 (phase=%0d a=%0d b=%0d pa=%0d pb=%0d)",
                       i, inv_got, bus.phase, bus.a, bus.b, bus.pa, bus.pb);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
